// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter for a shared 2:1 mux: registered select and one-hot grants,
// break-before-make gap between owners and a hold-timeout watchdog.
module mux_share_arbiter #(
    parameter int unsigned MaxHold   = 16,
    parameter int unsigned GapCycles = 1,
    parameter int unsigned CntW      = 5
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic [1:0] done_i,
    output logic [1:0] grant_o,
    output logic       select_o,
    output logic       busy_o,
    output logic       timeout_err_o
);

    typedef enum logic [1:0] {StIdle, StGrant0, StGrant1, StGap} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] hold_q, hold_d;
    logic [3:0]      gap_q, gap_d;
    logic            rr_last_q, rr_last_d;
    logic [1:0]      grant_q, grant_d;
    logic            select_q, select_d;
    logic            busy_q, busy_d;
    logic            terr_q, terr_d;

    logic owner;
    logic release_req;
    logic winner;

    assign owner       = (state_q == StGrant1);
    assign release_req = done_i[owner] | ~req_i[owner];
    // On a tie the requester that did not own last wins.
    assign winner      = (req_i == 2'b11) ? ~rr_last_q : req_i[1];

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        gap_d     = gap_q;
        rr_last_d = rr_last_q;
        grant_d   = grant_q;
        select_d  = select_q;
        busy_d    = busy_q;
        terr_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_i != 2'b00) begin
                    state_d  = winner ? StGrant1 : StGrant0;
                    grant_d  = winner ? 2'b10 : 2'b01;
                    select_d = winner;
                    busy_d   = 1'b1;
                    hold_d   = CntW'(1);
                end
            end
            StGrant0, StGrant1: begin
                if (release_req || (hold_q == CntW'(MaxHold))) begin
                    // Release wins over a coincident timeout; select is left on the old owner.
                    state_d   = StGap;
                    grant_d   = 2'b00;
                    busy_d    = 1'b0;
                    rr_last_d = owner;
                    gap_d     = 4'd0;
                    terr_d    = ~release_req;
                end else begin
                    hold_d = hold_q + CntW'(1);
                end
            end
            StGap: begin
                if (gap_q == 4'(GapCycles - 1)) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            gap_q     <= '0;
            rr_last_q <= 1'b1;
            grant_q   <= 2'b00;
            select_q  <= 1'b0;
            busy_q    <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            gap_q     <= gap_d;
            rr_last_q <= rr_last_d;
            grant_q   <= grant_d;
            select_q  <= select_d;
            busy_q    <= busy_d;
            terr_q    <= terr_d;
        end
    end

    assign grant_o       = grant_q;
    assign select_o      = select_q;
    assign busy_o        = busy_q;
    assign timeout_err_o = terr_q;

endmodule
